// File: rtl/key_debounce.sv
// Push-button conditioner for the four active-low board keys on the CLOCK_48 domain.
// Each key is synchronised, debounced by a four-state FSM, and reported as a stable level,
// a one-cycle press pulse, and press/release events queued in a small show-ahead FIFO.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 480000,
    parameter int unsigned CNT_W           = 19,
    parameter int unsigned FIFO_DEPTH      = 4
) (
    input  logic       CLOCK_48,
    input  logic       RESET_N,
    input  logic [3:0] KEY,
    output logic [3:0] KEY_STATE,
    output logic [3:0] KEY_PRESS,
    output logic       EVT_VALID,
    output logic [2:0] EVT_CODE,
    input  logic       EVT_READY,
    output logic       EVT_OVERFLOW
);

    localparam int unsigned    PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W:0] PTR_ONE  = (PTR_W + 1)'(1);

    typedef enum logic [1:0] {StUp, StPressWait, StDown, StReleaseWait} key_st_e;

    // Synchroniser stages; reset to 1 so a released key reads as released.
    logic [3:0] sync1_q, sync2_q;
    logic [3:0] s;

    key_st_e          state_q [4];
    key_st_e          state_d [4];
    logic [CNT_W-1:0] cnt_q   [4];
    logic [CNT_W-1:0] cnt_d   [4];
    logic [3:0]       key_state_q, key_state_d;
    logic [3:0]       key_press_q, key_press_d;

    // Event request from each FSM this cycle, and its polarity (1 = press).
    logic [3:0] evt_set, evt_press;

    // One pending event slot per key, waiting for the arbiter.
    logic [3:0] pend_q, pend_d;
    logic [3:0] pend_press_q, pend_press_d;
    logic       overflow_q, overflow_d;

    logic [3:0] grant;
    logic [2:0] push_code;
    logic       push, pop;

    logic [2:0]   mem_q [FIFO_DEPTH];
    logic [PTR_W:0] wr_ptr_q, rd_ptr_q;
    logic [2:0]   last_code_q;
    logic         fifo_empty, fifo_full;

    assign s = ~sync2_q;

    // Two-flop synchroniser per key.
    always_ff @(posedge CLOCK_48 or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1_q <= 4'hF;
            sync2_q <= 4'hF;
        end else begin
            sync1_q <= KEY;
            sync2_q <= sync1_q;
        end
    end

    // Per-key debounce FSM next state, level/pulse outputs and event requests.
    always_comb begin
        key_state_d = key_state_q;
        key_press_d = '0;
        evt_set     = '0;
        evt_press   = '0;
        for (int i = 0; i < 4; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            unique case (state_q[i])
                StUp: begin
                    if (s[i]) begin
                        state_d[i] = StPressWait;
                        cnt_d[i]   = '0;
                    end
                end
                StPressWait: begin
                    if (!s[i]) begin
                        state_d[i] = StUp;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i]     = StDown;
                        cnt_d[i]       = '0;
                        key_state_d[i] = 1'b1;
                        key_press_d[i] = 1'b1;
                        evt_set[i]     = 1'b1;
                        evt_press[i]   = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
                StDown: begin
                    if (!s[i]) begin
                        state_d[i] = StReleaseWait;
                        cnt_d[i]   = '0;
                    end
                end
                StReleaseWait: begin
                    if (s[i]) begin
                        state_d[i] = StDown;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i]     = StUp;
                        cnt_d[i]       = '0;
                        key_state_d[i] = 1'b0;
                        evt_set[i]     = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
            endcase
        end
    end

    // Debounce state registers.
    always_ff @(posedge CLOCK_48 or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= StUp;
                cnt_q[i]   <= '0;
            end
            key_state_q <= '0;
            key_press_q <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            key_state_q <= key_state_d;
            key_press_q <= key_press_d;
        end
    end

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign pop        = !fifo_empty && EVT_READY;
    // A pop frees a slot in the same cycle, so a full FIFO can still accept a push.
    assign push       = (|pend_q) && (!fifo_full || pop);

    // Lowest-index pending event wins the single write slot.
    always_comb begin
        grant     = '0;
        push_code = '0;
        for (int i = 3; i >= 0; i--) begin
            if (pend_q[i]) begin
                grant     = '0;
                grant[i]  = push;
                push_code = {pend_press_q[i], 2'(i)};
            end
        end
    end

    // Pending flags: cleared on grant, set by the FSM; an overwrite of an unserved
    // event is the only way an event can be lost.
    always_comb begin
        pend_d       = (pend_q & ~grant) | evt_set;
        pend_press_d = pend_press_q;
        for (int i = 0; i < 4; i++) begin
            if (evt_set[i]) begin
                pend_press_d[i] = evt_press[i];
            end
        end
        overflow_d = overflow_q | (|(evt_set & pend_q & ~grant));
    end

    // Pending slots and sticky overflow.
    always_ff @(posedge CLOCK_48 or negedge RESET_N) begin
        if (!RESET_N) begin
            pend_q       <= '0;
            pend_press_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            pend_q       <= pend_d;
            pend_press_q <= pend_press_d;
            overflow_q   <= overflow_d;
        end
    end

    // Event FIFO storage and pointers; the popped head is kept to hold EVT_CODE when empty.
    always_ff @(posedge CLOCK_48 or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            last_code_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q[PTR_W-1:0]] <= push_code;
                wr_ptr_q                   <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                last_code_q <= mem_q[rd_ptr_q[PTR_W-1:0]];
                rd_ptr_q    <= rd_ptr_q + PTR_ONE;
            end
        end
    end

    assign KEY_STATE    = key_state_q;
    assign KEY_PRESS    = key_press_q;
    assign EVT_VALID    = !fifo_empty;
    assign EVT_CODE     = fifo_empty ? last_code_q : mem_q[rd_ptr_q[PTR_W-1:0]];
    assign EVT_OVERFLOW = overflow_q;

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with a small debounce window; event codes are
// predicted into a scoreboard queue and compared as the DUT hands them out.
module tb_key_debounce;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] key;
    logic       ready;
    logic [3:0] key_state, key_press;
    logic       evt_valid, evt_overflow;
    logic [2:0] evt_code;

    int errors = 0;
    int checks = 0;
    logic [2:0] exp_q [$];

    logic [3:0] acc_state, acc_press;
    logic       acc_valid, acc_ovf;

    key_debounce #(
        .DEBOUNCE_CYCLES(8),
        .CNT_W          (4),
        .FIFO_DEPTH     (4)
    ) dut (
        .CLOCK_48    (clk),
        .RESET_N     (rst_n),
        .KEY         (key),
        .KEY_STATE   (key_state),
        .KEY_PRESS   (key_press),
        .EVT_VALID   (evt_valid),
        .EVT_CODE    (evt_code),
        .EVT_READY   (ready),
        .EVT_OVERFLOW(evt_overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int j = 0; j < n; j++) tick();
    endtask

    task automatic clr_acc();
        acc_state = '0;
        acc_press = '0;
        acc_valid = 1'b0;
        acc_ovf   = 1'b0;
    endtask

    task automatic tick_acc();
        tick();
        acc_state = acc_state | key_state;
        acc_press = acc_press | key_press;
        acc_valid = acc_valid | evt_valid;
        acc_ovf   = acc_ovf | evt_overflow;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        key   = 4'hF;
        ready = 1'b0;
        ticks(3);
        exp_q.delete();
        rst_n = 1'b1;
    endtask

    // Pop n events with EVT_READY high, comparing each head against the scoreboard.
    task automatic drain(input int n, input string tag);
        logic [2:0] exp_code;
        ready = 1'b1;
        for (int j = 0; j < n; j++) begin
            int w = 0;
            while (!evt_valid && w < 20) begin
                tick();
                w++;
            end
            check({tag, "_valid"}, 32'(evt_valid), 32'd1);
            exp_code = (exp_q.size() > 0) ? exp_q.pop_front() : 3'bxxx;
            if (evt_valid) check({tag, "_code"}, 32'(evt_code), 32'(exp_code));
            tick();
        end
        ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        key   = 4'hF;
        ready = 1'b0;

        // Reset state held for 50 cycles after release.
        do_reset();
        clr_acc();
        for (int j = 0; j < 50; j++) tick_acc();
        check("rst_state", 32'(acc_state), 32'd0);
        check("rst_press", 32'(acc_press), 32'd0);
        check("rst_valid", 32'(acc_valid), 32'd0);
        check("rst_ovf", 32'(acc_ovf), 32'd0);
        check("rst_code", 32'(evt_code), 32'd0);

        // Single press on KEY[1], exact latency, then release.
        key[1] = 1'b0;
        ticks(10);
        check("p1_state_early", 32'(key_state), 32'd0);
        tick();
        check("p1_state", 32'(key_state), 32'b0010);
        check("p1_pulse", 32'(key_press), 32'b0010);
        exp_q.push_back(3'b101);
        tick();
        check("p1_pulse_gone", 32'(key_press), 32'd0);
        check("p1_valid", 32'(evt_valid), 32'd1);
        check("p1_head", 32'(evt_code), 32'b101);
        key[1] = 1'b1;
        clr_acc();
        for (int j = 0; j < 10; j++) tick_acc();
        check("r1_state_early", 32'(key_state), 32'b0010);
        tick_acc();
        check("r1_state", 32'(key_state), 32'd0);
        check("r1_no_pulse", 32'(acc_press), 32'd0);
        exp_q.push_back(3'b001);
        ticks(2);
        drain(2, "k1");
        check("k1_empty", 32'(evt_valid), 32'd0);
        check("k1_hold_code", 32'(evt_code), 32'b001);

        // Bouncing KEY[0] never settles long enough.
        do_reset();
        clr_acc();
        for (int r = 0; r < 10; r++) begin
            key[0] = 1'b0;
            for (int j = 0; j < 5; j++) tick_acc();
            key[0] = 1'b1;
            for (int j = 0; j < 3; j++) tick_acc();
        end
        for (int j = 0; j < 12; j++) tick_acc();
        check("bounce_state", 32'(acc_state), 32'd0);
        check("bounce_press", 32'(acc_press), 32'd0);
        check("bounce_valid", 32'(acc_valid), 32'd0);

        // KEY[0] and KEY[2] together: same-edge rise, lowest index queued first.
        do_reset();
        key = 4'b1010;
        ticks(10);
        check("dual_state_early", 32'(key_state), 32'd0);
        tick();
        check("dual_state", 32'(key_state), 32'b0101);
        check("dual_pulse", 32'(key_press), 32'b0101);
        exp_q.push_back(3'b100);
        exp_q.push_back(3'b110);
        ticks(3);
        drain(2, "dual");
        check("dual_empty", 32'(evt_valid), 32'd0);
        check("dual_hold_code", 32'(evt_code), 32'b110);

        // Six events against a four-entry FIFO: two wait as pending, none lost.
        do_reset();
        key = 4'b1000;
        ticks(11);
        check("six_press_state", 32'(key_state), 32'b0111);
        exp_q.push_back(3'b100);
        exp_q.push_back(3'b101);
        exp_q.push_back(3'b110);
        key = 4'hF;
        ticks(11);
        check("six_rel_state", 32'(key_state), 32'd0);
        exp_q.push_back(3'b000);
        exp_q.push_back(3'b001);
        exp_q.push_back(3'b010);
        ticks(4);
        check("six_valid", 32'(evt_valid), 32'd1);
        check("six_ovf", 32'(evt_overflow), 32'd0);
        drain(6, "six");
        check("six_empty", 32'(evt_valid), 32'd0);
        check("six_ovf_after", 32'(evt_overflow), 32'd0);

        // Overflow: pending slot overwritten while FIFO full.
        do_reset();
        for (int r = 0; r < 3; r++) begin
            key[0] = 1'b0;
            ticks(12);
            key[0] = 1'b1;
            ticks(12);
        end
        check("ovf_set", 32'(evt_overflow), 32'd1);
        exp_q.push_back(3'b100);
        exp_q.push_back(3'b000);
        exp_q.push_back(3'b100);
        exp_q.push_back(3'b000);
        exp_q.push_back(3'b000);
        drain(5, "ovf");
        check("ovf_empty", 32'(evt_valid), 32'd0);
        check("ovf_sticky", 32'(evt_overflow), 32'd1);

        // Reset in the middle of PRESS_WAIT on KEY[3]; key stays held.
        do_reset();
        key[3] = 1'b0;
        ticks(7);
        rst_n = 1'b0;
        #1;
        check("mid_rst_state", 32'(key_state), 32'd0);
        check("mid_rst_valid", 32'(evt_valid), 32'd0);
        check("mid_rst_ovf", 32'(evt_overflow), 32'd0);
        ticks(3);
        check("mid_rst_hold", 32'({key_state, key_press, evt_valid, evt_code, evt_overflow}),
              32'd0);
        rst_n = 1'b1;
        ticks(10);
        check("k3_state_early", 32'(key_state), 32'd0);
        tick();
        check("k3_state", 32'(key_state), 32'b1000);
        check("k3_pulse", 32'(key_press), 32'b1000);
        exp_q.push_back(3'b111);
        drain(1, "k3");
        check("k3_empty", 32'(evt_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Input-side counterpart to the LED output logic: conditions the board's four raw active-low push-buttons on the CLOCK_48 domain.
- Per key: synchronises, debounces, tracks a stable pressed/released state and emits a one-cycle press pulse.
- Queues press/release events in a small show-ahead FIFO with a valid/ready handshake. Downstream logic (LED pattern control, CNN test triggers) consumes these events.

Parameters:
DEBOUNCE_CYCLES, 480000, consecutive stable synchronised samples required to accept a level change (10 ms at 48 MHz); must be >= 2
CNT_W, 19, debounce counter width; must satisfy 2^CNT_W >= DEBOUNCE_CYCLES
FIFO_DEPTH, 4, event FIFO entries; power of two

Ports:
CLOCK_48  input  1  system clock, 48 MHz
RESET_N  input  1  asynchronous active-low reset
KEY  input  4  raw buttons, active-low (0 = pressed), asynchronous to CLOCK_48
KEY_STATE  output  4  debounced level per key, 1 = pressed
KEY_PRESS  output  4  one-cycle pulse on the cycle KEY_STATE[i] rises
EVT_VALID  output  1  FIFO non-empty
EVT_CODE  output  3  FIFO head: bit2 = 1 press / 0 release, bits1:0 = key index
EVT_READY  input  1  consumer accepts head when EVT_VALID && EVT_READY at a rising edge
EVT_OVERFLOW  output  1  sticky: an event was lost; cleared only by reset

Behaviour:
- Reset (RESET_N low, asynchronous): synchroniser flops = 1 (released); all per-key FSMs = UP; counters = 0; pending flags = 0; FIFO empty.
- Output reset values: KEY_STATE = 0, KEY_PRESS = 0, EVT_VALID = 0, EVT_CODE = 0, EVT_OVERFLOW = 0.
- Synchroniser: two flops per key. The second stage is the sample "s", inverted so that 1 = pressed.
- Per-key FSM states: UP, PRESS_WAIT, DOWN, RELEASE_WAIT.
  - UP: if s=1, go to PRESS_WAIT with cnt=0.
  - PRESS_WAIT: if s=0, return to UP with cnt=0 (bounce rejected). Otherwise, if cnt == DEBOUNCE_CYCLES-1, go to DOWN, set KEY_STATE[i]=1, pulse KEY_PRESS[i], and set pending[i] with code press. Otherwise cnt++.
  - DOWN: if s=0, go to RELEASE_WAIT with cnt=0.
  - RELEASE_WAIT: mirror of PRESS_WAIT. If s=1, return to DOWN. At the terminal count, go to UP, clear KEY_STATE[i], and set pending[i] with code release. No pulse on release.
- Latency: raw KEY[i] held low from before edge k makes KEY_STATE[i] high and KEY_PRESS[i] high after edge k+DEBOUNCE_CYCLES+2, exactly.
- KEY_PRESS[i] is high for exactly one cycle.
- Keys are fully independent; several may change in the same cycle.
- Event arbiter:
  - Each cycle, if any pending[i] is set and the FIFO is not full (or is popped this same cycle), write the lowest-index pending event and clear that flag.
  - Exactly one write per cycle.
  - Pending events wait while the FIFO is full; no loss from fullness alone.
- Overflow:
  - A key's FSM sets pending[i] while pending[i] is already 1: the newer event overwrites the older one and EVT_OVERFLOW is set.
  - This is the only loss mechanism.
- FIFO:
  - Show-ahead: EVT_CODE equals the head whenever EVT_VALID=1. EVT_CODE holds its last value when empty (0 after reset).
  - Pop occurs on edge with EVT_VALID && EVT_READY.
  - Simultaneous push and pop is legal at any occupancy, including full; occupancy is then unchanged.
  - EVT_READY while empty has no effect.
  - Pointers are CNT-free wrap-around modulo FIFO_DEPTH, with an extra MSB for full/empty.
- Reset mid-debounce or mid-FIFO: everything returns to the reset state. A key still held after reset release requires a full DEBOUNCE_CYCLES+2 to be reported.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=8, CNT_W=4, FIFO_DEPTH=4.
1. Hold RESET_N=0 with KEY=4'hF, then release -> KEY_STATE=0, KEY_PRESS=0, EVT_VALID=0, EVT_OVERFLOW=0 for 50 cycles.
2. Drive KEY[1]=0 before edge k and hold -> KEY_STATE[1]=1 and KEY_PRESS=4'b0010 after edge k+10, pulse gone after k+11; EVT_VALID=1 with EVT_CODE=3'b101. Then release KEY[1] -> KEY_STATE[1]=0 10 edges later, second event 3'b001, no KEY_PRESS.
3. Toggle KEY[0] low 5 cycles / high 3 cycles, repeated 10 times -> KEY_STATE, KEY_PRESS and EVT_VALID stay 0.
4. Drop KEY[0] and KEY[2] on the same cycle with EVT_READY=0 -> both KEY_STATE bits rise on the same edge. FIFO holds 3'b100 then 3'b110. With EVT_READY=1 they pop in that order.
5. With EVT_READY=0, generate press+release on KEY[0..2] (6 events) -> EVT_VALID=1 with 4 entries queued, 2 pending, EVT_OVERFLOW=0. Raise EVT_READY -> all 6 codes drain in generation order, then EVT_VALID=0.
6. Assert RESET_N=0 when KEY[3] is 4 cycles into PRESS_WAIT, keep KEY[3] low, then release reset at edge r -> all outputs 0 during reset; KEY_STATE[3] rises exactly after edge r+10.
